// File: rtl/prog_loader.sv
// prog_loader: boot-time program loader for the core's instruction memory.
// Receives a byte stream made of a 16-bit little-endian word count N and then
// N little-endian 32-bit words. Each word is written to sequential imem
// addresses. The core is held in reset until the image is complete and valid.
// Optional feature macro: PROG_LOADER_CKSUM_EN. When it is defined, one trailing
// checksum byte follows the data. It must equal the XOR of all count and data bytes.
//
// Handshake: a byte transfers on a rising clk edge when rx_valid && rx_ready.
// rx_ready depends only on state, never on rx_valid. It is high in every state
// except DONE. Idle cycles on rx_valid change nothing.
module prog_loader #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              restart,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              err,
    output logic [2:0]        dbg_state
);

    localparam int             DEPTH   = 1 << ADDR_W;
    localparam logic [CNT_W:0] DEPTH_V = (CNT_W+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_HDR0 = 3'd0,
        S_HDR1 = 3'd1,
        S_DATA = 3'd2,
`ifdef PROG_LOADER_CKSUM_EN
        S_CHK  = 3'd3,
`endif
        S_DONE = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_word_idx;
    logic [1:0]        r_byte_idx;
    logic [23:0]       r_shift;
`ifdef PROG_LOADER_CKSUM_EN
    logic [7:0]        r_cksum;
`endif

    logic              w_accept;
    logic [CNT_W-1:0]  w_count_full;
    logic              w_last_word;
    logic              w_in_range;

    assign w_accept     = rx_valid && rx_ready;
    assign w_count_full = {rx_data, r_count[7:0]};
    assign w_last_word  = (r_word_idx == (r_count - CNT_W'(1)));
    assign w_in_range   = ({1'b0, r_word_idx} < DEPTH_V);
    assign dbg_state    = r_state;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_HDR0;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and the byte-ready flag.
    always_comb begin
        w_next   = r_state;
        rx_ready = 1'b1;
        unique case (r_state)
            S_HDR0: begin
                if (w_accept) w_next = S_HDR1;
            end
            S_HDR1: begin
                if (w_accept) begin
                    if (w_count_full == '0) begin
`ifdef PROG_LOADER_CKSUM_EN
                        w_next = S_CHK;
`else
                        w_next = S_DONE;
`endif
                    end else begin
                        w_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_accept && (r_byte_idx == 2'd3) && w_last_word) begin
`ifdef PROG_LOADER_CKSUM_EN
                    w_next = S_CHK;
`else
                    w_next = S_DONE;
`endif
                end
            end
`ifdef PROG_LOADER_CKSUM_EN
            S_CHK: begin
                if (w_accept) w_next = S_DONE;
            end
`endif
            S_DONE: begin
                rx_ready = 1'b0;
                if (restart) w_next = S_HDR0;
            end
            default: begin
                w_next = S_HDR0;
            end
        endcase
    end

    // Datapath: header capture, word assembly, imem write, and status flags.
    // done and core_reset are registered. They change the cycle after DONE is
    // entered, so they follow the final write by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= '0;
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_shift    <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_reset <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
`ifdef PROG_LOADER_CKSUM_EN
            r_cksum    <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            unique case (r_state)
                S_HDR0: begin
                    if (w_accept) begin
                        r_count <= {r_count[CNT_W-1:8], rx_data};
`ifdef PROG_LOADER_CKSUM_EN
                        r_cksum <= r_cksum ^ rx_data;
`endif
                    end
                end
                S_HDR1: begin
                    if (w_accept) begin
                        r_count <= w_count_full;
                        if ({1'b0, w_count_full} > DEPTH_V) err <= 1'b1;
`ifdef PROG_LOADER_CKSUM_EN
                        r_cksum <= r_cksum ^ rx_data;
`endif
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_shift    <= {rx_data, r_shift[23:8]};
                        r_byte_idx <= r_byte_idx + 2'd1;
`ifdef PROG_LOADER_CKSUM_EN
                        r_cksum    <= r_cksum ^ rx_data;
`endif
                        if (r_byte_idx == 2'd3) begin
                            r_word_idx <= r_word_idx + CNT_W'(1);
                            // Words past the end of imem are consumed but not written.
                            if (w_in_range) begin
                                imem_we    <= 1'b1;
                                imem_wdata <= {rx_data, r_shift};
                                imem_addr  <= r_word_idx[ADDR_W-1:0];
                            end
                        end
                    end
                end
`ifdef PROG_LOADER_CKSUM_EN
                S_CHK: begin
                    if (w_accept && (rx_data != r_cksum)) err <= 1'b1;
                end
`endif
                S_DONE: begin
                    if (restart) begin
                        done       <= 1'b0;
                        err        <= 1'b0;
                        core_reset <= 1'b1;
                        r_count    <= '0;
                        r_word_idx <= '0;
                        r_byte_idx <= '0;
                        r_shift    <= '0;
`ifdef PROG_LOADER_CKSUM_EN
                        r_cksum    <= '0;
`endif
                    end else begin
                        done       <= 1'b1;
                        core_reset <= err;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
